// File: rtl/mem_cache_arbiter_if.sv
// Requester and cache signal bundle for mem_cache_arbiter.
// slave is the arbiter view; master is the requester/cache view.
interface mem_cache_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_ack;
    logic [DATA_W-1:0] r0_rdata;
    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_ack;
    logic [DATA_W-1:0] r1_rdata;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_wr_req;
    logic              c_rd_req;
    logic [DATA_W-1:0] c_rdata;
    logic              c_hit;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  c_rdata, c_hit,
        output r0_ack, r0_rdata, r1_ack, r1_rdata,
        output c_addr, c_wdata, c_wr_req, c_rd_req
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output c_rdata, c_hit,
        input  r0_ack, r0_rdata, r1_ack, r1_rdata,
        input  c_addr, c_wdata, c_wr_req, c_rd_req
    );
endinterface

// File: rtl/mem_cache_arbiter.sv
// Round-robin two-requester arbiter sequencing single accesses
// into a single-port cache, with saturating hit/miss statistics.
module mem_cache_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rstn,
    mem_cache_arbiter_if.slave bus,
    output logic               busy,
    output logic               grant_id,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              last_grant;
    logic              grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              take;
    logic              win;

    // Pick a winner; on a tie the loser of the previous grant goes.
    always_comb begin
        take = bus.r0_req | bus.r1_req;
        win  = 1'b0;
        if (bus.r0_req && bus.r1_req) begin
            win = ~last_grant;
        end else begin
            win = bus.r1_req;
        end
    end

    // Next state: wait for a request, then one access and one ack cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (take) state_nx = ISSUE;
            ISSUE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Latch the winner's fields at grant so later input changes are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (state == IDLE && take) begin
            last_grant <= win;
            grant_q    <= win;
            we_q       <= win ? bus.r1_we    : bus.r0_we;
            addr_q     <= win ? bus.r1_addr  : bus.r0_addr;
            wdata_q    <= win ? bus.r1_wdata : bus.r0_wdata;
        end
    end

    // Capture read data and count hit or miss as the access closes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q  <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == ISSUE) begin
            if (!we_q) begin
                rdata_q <= bus.c_rdata;
            end
            if (bus.c_hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.c_addr   = addr_q;
    assign bus.c_wdata  = wdata_q;
    assign bus.c_rd_req = (state == ISSUE) & ~we_q;
    assign bus.c_wr_req = (state == ISSUE) & we_q;
    assign bus.r0_ack   = (state == RESP) & ~grant_q;
    assign bus.r1_ack   = (state == RESP) & grant_q;
    assign bus.r0_rdata = rdata_q;
    assign bus.r1_rdata = rdata_q;
    assign busy         = (state != IDLE);
    assign grant_id     = grant_q;
endmodule

// File: tb/tb_mem_cache_arbiter.sv
// Bench for mem_cache_arbiter: behavioural cache plus a
// transaction-level reference of memory contents and hit/miss counts.
module tb_mem_cache_arbiter;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mem_cache_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();
    mem_cache_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus_s ();

    logic        busy, grant_id;
    logic [15:0] hit_cnt, miss_cnt;
    logic        busy_s, grant_id_s;
    logic [2:0]  hit_s, miss_s;

    mem_cache_arbiter #(.ADDR_W(8), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .busy(busy),
        .grant_id(grant_id), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    mem_cache_arbiter #(.ADDR_W(8), .DATA_W(32), .CNT_W(3)) dut_s (
        .clk(clk), .rstn(rstn), .bus(bus_s), .busy(busy_s),
        .grant_id(grant_id_s), .hit_cnt(hit_s), .miss_cnt(miss_s)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] base_word(input logic [7:0] a);
        return 32'hA5A5_0000 ^ (32'h9E37_79B9 * {24'h0, a});
    endfunction

    // Behavioural cache: a line becomes present once accessed.
    logic [31:0] cmem [256];
    logic        cwr  [256];
    logic        cval [256];
    logic        cache_clr;
    assign bus.c_rdata = cwr[bus.c_addr] ? cmem[bus.c_addr] : base_word(bus.c_addr);
    assign bus.c_hit   = cval[bus.c_addr];
    assign bus_s.c_rdata = 32'h0;
    assign bus_s.c_hit   = 1'b1;

    always @(posedge clk) begin
        if (cache_clr) begin
            for (int i = 0; i < 256; i++) begin
                cwr[i]  <= 1'b0;
                cval[i] <= 1'b0;
            end
        end else begin
            if (bus.c_wr_req) begin
                cmem[bus.c_addr] <= bus.c_wdata;
                cwr[bus.c_addr]  <= 1'b1;
                cval[bus.c_addr] <= 1'b1;
            end
            if (bus.c_rd_req) cval[bus.c_addr] <= 1'b1;
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];
    bit          ref_seen[256];
    int          exp_hit = 0;
    int          exp_miss = 0;
    bit          ref_last = 1'b1;
    logic [31:0] ref_rd = 32'h0;

    task automatic model_txn(input bit k, input bit we, input logic [7:0] a,
                             input logic [31:0] wd, output logic [31:0] rd);
        if (ref_seen[a]) begin
            if (exp_hit < 65535) exp_hit++;
        end else begin
            if (exp_miss < 65535) exp_miss++;
        end
        ref_seen[a] = 1'b1;
        if (we) begin
            ref_mem[a] = wd;
            ref_wr[a]  = 1'b1;
        end else begin
            ref_rd = ref_wr[a] ? ref_mem[a] : base_word(a);
        end
        rd = ref_rd;
        ref_last = k;
    endtask

    task automatic set_req(input bit k, input bit req, input bit we,
                           input logic [7:0] a, input logic [31:0] wd);
        if (k) begin
            bus.r1_req = req; bus.r1_we = we;
            bus.r1_addr = a; bus.r1_wdata = wd;
        end else begin
            bus.r0_req = req; bus.r0_we = we;
            bus.r0_addr = a; bus.r0_wdata = wd;
        end
    endtask

    task automatic run_one(input bit k, input bit we, input logic [7:0] a,
                           input logic [31:0] wd, output int lat,
                           output logic [31:0] rd, output int nrd, output int nwr,
                           output logic [7:0] ca, output logic [31:0] cwd,
                           output bit got, output bit wa);
        lat = 0; rd = '0; nrd = 0; nwr = 0;
        ca = '0; cwd = '0; got = 1'b0; wa = 1'b0;
        @(negedge clk);
        set_req(k, 1'b1, we, a, wd);
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (bus.c_rd_req) begin nrd++; ca = bus.c_addr; end
            if (bus.c_wr_req) begin
                nwr++; ca = bus.c_addr; cwd = bus.c_wdata;
            end
            if (k ? bus.r0_ack : bus.r1_ack) wa = 1'b1;
            if (k ? bus.r1_ack : bus.r0_ack) begin
                got = 1'b1; lat = i;
                rd = k ? bus.r1_rdata : bus.r0_rdata;
            end
        end
        set_req(k, 1'b0, we, a, wd);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        cache_clr = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.r0_ack !== 1'b0) begin bad++; $display("FAIL rst_r0_ack got=%0b want=0", bus.r0_ack); end
        total++; if (bus.r1_ack !== 1'b0) begin bad++; $display("FAIL rst_r1_ack got=%0b want=0", bus.r1_ack); end
        total++; if (bus.c_rd_req !== 1'b0 || bus.c_wr_req !== 1'b0) begin
            bad++; $display("FAIL rst_creq got=%0b%0b want=00", bus.c_rd_req, bus.c_wr_req); end
        total++; if (bus.c_addr !== 8'h0) begin bad++; $display("FAIL rst_caddr got=%0h want=0", bus.c_addr); end
        total++; if (bus.c_wdata !== 32'h0) begin bad++; $display("FAIL rst_cwdata got=%0h want=0", bus.c_wdata); end
        total++; if (bus.r0_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h want=0", bus.r0_rdata); end
        total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL rst_grant got=%0b want=0", grant_id); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
        total++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
            bad++; $display("FAIL rst_cnt got=%0h/%0h want=0/0", hit_cnt, miss_cnt); end
        total++; if (hit_s !== 3'h0 || miss_s !== 3'h0 || busy_s !== 1'b0 || grant_id_s !== 1'b0) begin
            bad++; $display("FAIL rst_small got=%0h/%0h/%0b/%0b want=0", hit_s, miss_s, busy_s, grant_id_s); end
        cache_clr = 1'b0;
        rstn = 1'b1;
    endtask

    task automatic test_cold_read;
        int lat, nrd, nwr; logic [31:0] rd, cwd, erd; logic [7:0] ca; bit got, wa;
        run_one(1'b0, 1'b0, 8'h12, 32'h0, lat, rd, nrd, nwr, ca, cwd, got, wa);
        model_txn(1'b0, 1'b0, 8'h12, 32'h0, erd);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL cold_ack got=%0b want=1", got); end
        total++; if (lat !== 2) begin bad++; $display("FAIL cold_latency got=%0d want=2", lat); end
        total++; if (nrd !== 1 || nwr !== 0) begin bad++; $display("FAIL cold_creq got=rd%0d/wr%0d want=rd1/wr0", nrd, nwr); end
        total++; if (ca !== 8'h12) begin bad++; $display("FAIL cold_caddr got=%0h want=12", ca); end
        total++; if (wa !== 1'b0) begin bad++; $display("FAIL cold_wrong_ack got=%0b want=0", wa); end
        total++; if (rd !== erd) begin bad++; $display("FAIL cold_rdata got=%0h want=%0h", rd, erd); end
        total++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd1) begin
            bad++; $display("FAIL cold_cnt got=%0d/%0d want=0/1", hit_cnt, miss_cnt); end
    endtask

    task automatic test_hit_read;
        int lat, nrd, nwr; logic [31:0] rd, cwd, erd; logic [7:0] ca; bit got, wa;
        run_one(1'b0, 1'b0, 8'h12, 32'h0, lat, rd, nrd, nwr, ca, cwd, got, wa);
        model_txn(1'b0, 1'b0, 8'h12, 32'h0, erd);
        total++; if (got !== 1'b1 || rd !== erd) begin bad++; $display("FAIL hit_rdata got=%0h want=%0h", rd, erd); end
        total++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
            bad++; $display("FAIL hit_cnt got=%0d/%0d want=1/1", hit_cnt, miss_cnt); end
    endtask

    task automatic test_write_then_read;
        int lat, nrd, nwr; logic [31:0] rd, cwd, erd; logic [7:0] ca; bit got, wa;
        run_one(1'b1, 1'b1, 8'h12, 32'hDEADBEEF, lat, rd, nrd, nwr, ca, cwd, got, wa);
        model_txn(1'b1, 1'b1, 8'h12, 32'hDEADBEEF, erd);
        total++; if (got !== 1'b1 || lat !== 2) begin bad++; $display("FAIL wr_ack got=%0b lat=%0d want=1 lat=2", got, lat); end
        total++; if (nwr !== 1 || nrd !== 0) begin bad++; $display("FAIL wr_creq got=rd%0d/wr%0d want=rd0/wr1", nrd, nwr); end
        total++; if (cwd !== 32'hDEADBEEF || ca !== 8'h12) begin
            bad++; $display("FAIL wr_cbus got=%0h@%0h want=deadbeef@12", cwd, ca); end
        total++; if (wa !== 1'b0) begin bad++; $display("FAIL wr_wrong_ack got=%0b want=0", wa); end
        total++; if (rd !== erd) begin bad++; $display("FAIL wr_rdata_kept got=%0h want=%0h", rd, erd); end
        run_one(1'b0, 1'b0, 8'h12, 32'h0, lat, rd, nrd, nwr, ca, cwd, got, wa);
        model_txn(1'b0, 1'b0, 8'h12, 32'h0, erd);
        total++; if (got !== 1'b1 || rd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL wr_readback got=%0h want=deadbeef", rd); end
        total++; if (hit_cnt !== 16'(exp_hit) || miss_cnt !== 16'(exp_miss)) begin
            bad++; $display("FAIL wr_cnt got=%0d/%0d want=%0d/%0d", hit_cnt, miss_cnt, exp_hit, exp_miss); end
    endtask

    task automatic test_alternate;
        bit cwe[2]; logic [7:0] cad[2]; logic [31:0] cwdv[2];
        logic [31:0] erd, rd; bit k, exp_g; int n, last_cyc;
        n = 0; last_cyc = 0; exp_g = ~ref_last;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            cwe[j] = 1'($urandom_range(0, 1));
            cad[j] = 8'($urandom_range(0, 15));
            cwdv[j] = $urandom;
            set_req(j[0], 1'b1, cwe[j], cad[j], cwdv[j]);
        end
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(negedge clk);
            if (bus.r0_ack && bus.r1_ack) begin
                total++; bad++; $display("FAIL alt_dual_ack got=11 want=one-hot");
            end else if (bus.r0_ack || bus.r1_ack) begin
                k = bus.r1_ack;
                rd = k ? bus.r1_rdata : bus.r0_rdata;
                total++; if (k !== exp_g) begin bad++; $display("FAIL alt_order n=%0d got=%0b want=%0b", n, k, exp_g); end
                total++; if (grant_id !== exp_g) begin bad++; $display("FAIL alt_grant_id got=%0b want=%0b", grant_id, exp_g); end
                model_txn(k, cwe[k], cad[k], cwdv[k], erd);
                total++; if (rd !== erd) begin bad++; $display("FAIL alt_rdata got=%0h want=%0h", rd, erd); end
                if (n > 0) begin
                    total++; if (cyc - last_cyc !== 3) begin
                        bad++; $display("FAIL alt_spacing got=%0d want=3", cyc - last_cyc); end
                end
                last_cyc = cyc; n++; exp_g = ~exp_g;
                cwe[k] = 1'($urandom_range(0, 1));
                cad[k] = 8'($urandom_range(0, 15));
                cwdv[k] = $urandom;
                set_req(k, 1'b1, cwe[k], cad[k], cwdv[k]);
            end
        end
        set_req(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 8'h0, 32'h0);
        total++; if (n !== 6) begin bad++; $display("FAIL alt_count got=%0d want=6", n); end
        total++; if (hit_cnt !== 16'(exp_hit) || miss_cnt !== 16'(exp_miss)) begin
            bad++; $display("FAIL alt_cnt got=%0d/%0d want=%0d/%0d", hit_cnt, miss_cnt, exp_hit, exp_miss); end
    endtask

    task automatic test_addr_change;
        logic [31:0] rd, erd; bit got;
        got = 1'b0; rd = '0;
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 8'h05, 32'h0);
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (i == 1) begin
                total++; if (bus.c_rd_req !== 1'b1 || bus.c_addr !== 8'h05) begin
                    bad++; $display("FAIL chg_caddr got=%0b@%0h want=1@05", bus.c_rd_req, bus.c_addr); end
                bus.r0_addr = 8'h06;
            end
            if (bus.r0_ack) begin got = 1'b1; rd = bus.r0_rdata; end
        end
        set_req(1'b0, 1'b0, 1'b0, 8'h06, 32'h0);
        model_txn(1'b0, 1'b0, 8'h05, 32'h0, erd);
        total++; if (got !== 1'b1 || rd !== erd) begin bad++; $display("FAIL chg_rdata got=%0h want=%0h", rd, erd); end
    endtask

    task automatic test_reset_abort;
        bit ack_seen, k; int n; logic [31:0] rd, erd;
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 8'h33, 32'h0);
        @(negedge clk);
        total++; if (bus.c_rd_req !== 1'b1) begin bad++; $display("FAIL abort_issue got=%0b want=1", bus.c_rd_req); end
        #1 rstn = 1'b0;
        #1;
        total++; if (bus.c_rd_req !== 1'b0 || bus.c_wr_req !== 1'b0) begin
            bad++; $display("FAIL abort_creq got=%0b%0b want=00", bus.c_rd_req, bus.c_wr_req); end
        total++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_state got=%0d/%0d/%0b want=0/0/0", hit_cnt, miss_cnt, busy); end
        set_req(1'b0, 1'b0, 1'b0, 8'h33, 32'h0);
        ack_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.r0_ack || bus.r1_ack) ack_seen = 1'b1;
        end
        total++; if (ack_seen !== 1'b0) begin bad++; $display("FAIL abort_ack got=1 want=0"); end
        rstn = 1'b1;
        exp_hit = 0; exp_miss = 0; ref_last = 1'b1; ref_rd = 32'h0;
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 8'h20, 32'h0);
        set_req(1'b1, 1'b1, 1'b1, 8'h21, 32'h1234_5678);
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge clk);
            if (bus.r0_ack || bus.r1_ack) begin
                k = bus.r1_ack;
                rd = k ? bus.r1_rdata : bus.r0_rdata;
                total++; if (k !== n[0]) begin bad++; $display("FAIL post_rst_order n=%0d got=%0b want=%0b", n, k, n[0]); end
                if (k) model_txn(1'b1, 1'b1, 8'h21, 32'h1234_5678, erd);
                else model_txn(1'b0, 1'b0, 8'h20, 32'h0, erd);
                total++; if (rd !== erd) begin bad++; $display("FAIL post_rst_rdata got=%0h want=%0h", rd, erd); end
                set_req(k, 1'b0, 1'b0, 8'h0, 32'h0);
                n++;
            end
        end
        set_req(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 8'h0, 32'h0);
        total++; if (n !== 2) begin bad++; $display("FAIL post_rst_count got=%0d want=2", n); end
        total++; if (hit_cnt !== 16'(exp_hit) || miss_cnt !== 16'(exp_miss)) begin
            bad++; $display("FAIL post_rst_cnt got=%0d/%0d want=%0d/%0d", hit_cnt, miss_cnt, exp_hit, exp_miss); end
    endtask

    task automatic test_saturation;
        bit got; int e;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            bus_s.r0_req = 1'b1; bus_s.r0_we = 1'b0; bus_s.r0_addr = 8'(n);
            got = 1'b0;
            for (int i = 0; i < 6 && !got; i++) begin
                @(negedge clk);
                if (bus_s.r0_ack) got = 1'b1;
            end
            bus_s.r0_req = 1'b0;
            e = (n > 7) ? 7 : n;
            total++; if (got !== 1'b1 || hit_s !== 3'(e)) begin
                bad++; $display("FAIL sat_hit n=%0d got=%0d ack=%0b want=%0d", n, hit_s, got, e); end
        end
        total++; if (miss_s !== 3'h0) begin bad++; $display("FAIL sat_miss got=%0d want=0", miss_s); end
    endtask

    task automatic test_random;
        bit act[2]; bit cwe[2]; logic [7:0] cad[2]; logic [31:0] cwdv[2];
        logic [31:0] rd, erd; bit a; int done;
        act[0] = 1'b0; act[1] = 1'b0; done = 0;
        for (int i = 0; i < 420; i++) begin
            @(negedge clk);
            if (bus.r0_ack && bus.r1_ack) begin
                total++; bad++; $display("FAIL rnd_dual_ack got=11 want=one-hot");
            end
            for (int j = 0; j < 2; j++) begin
                a = j ? bus.r1_ack : bus.r0_ack;
                if (a) begin
                    rd = j ? bus.r1_rdata : bus.r0_rdata;
                    total++; if (act[j] !== 1'b1) begin bad++; $display("FAIL rnd_spurious_ack req=%0d got=1 want=0", j); end
                    if (act[j]) begin
                        model_txn(j[0], cwe[j], cad[j], cwdv[j], erd);
                        total++; if (rd !== erd) begin
                            bad++; $display("FAIL rnd_rdata req=%0d a=%0h got=%0h want=%0h", j, cad[j], rd, erd); end
                        total++; if (hit_cnt !== 16'(exp_hit) || miss_cnt !== 16'(exp_miss)) begin
                            bad++; $display("FAIL rnd_cnt got=%0d/%0d want=%0d/%0d", hit_cnt, miss_cnt, exp_hit, exp_miss); end
                        done++;
                    end
                    act[j] = 1'b0;
                    set_req(j[0], 1'b0, 1'b0, 8'h0, 32'h0);
                end else if (!act[j] && i < 400 && $urandom_range(0, 3) == 0) begin
                    cwe[j] = 1'($urandom_range(0, 1));
                    cad[j] = 8'($urandom_range(0, 15));
                    cwdv[j] = $urandom;
                    set_req(j[0], 1'b1, cwe[j], cad[j], cwdv[j]);
                    act[j] = 1'b1;
                end
            end
        end
        total++; if (act[0] || act[1]) begin bad++; $display("FAIL rnd_drain got=%0b%0b want=00", act[1], act[0]); end
        total++; if (done < 20) begin bad++; $display("FAIL rnd_done got=%0d want>=20", done); end
    endtask

    initial begin
        rstn = 1'b0;
        cache_clr = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 8'h0, 32'h0);
        bus_s.r0_req = 1'b0; bus_s.r0_we = 1'b0;
        bus_s.r0_addr = 8'h0; bus_s.r0_wdata = 32'h0;
        bus_s.r1_req = 1'b0; bus_s.r1_we = 1'b0;
        bus_s.r1_addr = 8'h0; bus_s.r1_wdata = 32'h0;
        test_reset;
        test_cold_read;
        test_hit_read;
        test_write_then_read;
        test_alternate;
        test_addr_change;
        test_reset_abort;
        test_saturation;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
